// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the frame validity rule for the PS/2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam int NUM_KEYS = 7;

    // Element 0 is key A; the order matches the key output bundle in the top.
    localparam logic [NUM_KEYS-1:0][7:0] KEY_CODES =
        {SC_ESC, SC_SPACE, SC_S, SC_X, SC_D, SC_W, SC_A};

    // frame[0] = start, frame[8:1] = data LSB first, frame[9] = odd parity, frame[10] = stop.
    function automatic logic frame_ok(input logic [10:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit framing FSM,
// parity/start/stop check and inter-edge timeout. Emits single-cycle strobes.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_bad_o,
    output logic       timeout_o
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] TMO = IDLE_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    rx_state_t              state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic                   fall;
    logic                   bit_in;
    logic [10:0]            frame_w;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign bit_in  = data_sync_q[SYNC_STAGES-1];
    assign frame_w = {bit_in, shift_q};
    assign byte_o  = frame_w[8:1];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_bad_o  = 1'b0;
        timeout_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = RECV;
                    bit_cnt_d  = 4'd1;
                    idle_cnt_d = '0;
                    shift_d    = frame_w[10:1];
                end
            end
            RECV: begin
                // An edge on the terminal-count cycle still counts as a bit.
                if (fall) begin
                    idle_cnt_d = '0;
                    shift_d    = frame_w[10:1];
                    if (bit_cnt_q == 4'd10) begin
                        state_d      = CHECK;
                        bit_cnt_d    = 4'd0;
                        byte_valid_o = frame_ok(frame_w);
                        frame_bad_o  = ~frame_ok(frame_w);
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (idle_cnt_q == TMO) begin
                    timeout_o  = 1'b1;
                    state_d    = IDLE;
                    bit_cnt_d  = 4'd0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            idle_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: tracks break/extended prefixes and holds a level per mapped key.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       key_A,
    output logic       key_W,
    output logic       key_D,
    output logic       key_X,
    output logic       key_S,
    output logic       key_space,
    output logic       key_esc,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                rx_bad;
    logic                rx_timeout;
    logic                plain_byte;
    logic [7:0]          scan_code_q, scan_code_d;
    logic                scan_valid_q, scan_valid_d;
    logic                frame_error_q, frame_error_d;
    logic                break_pend_q, break_pend_d;
    logic                ext_pend_q, ext_pend_d;
    logic [NUM_KEYS-1:0] key_q;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_i    (PS2_CLK),
        .ps2_data_i   (PS2_DATA),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_bad_o  (rx_bad),
        .timeout_o    (rx_timeout)
    );

    assign plain_byte = rx_valid && (rx_byte != SC_BREAK) && (rx_byte != SC_EXT);

    // A timeout only aborts the frame; a corrupted frame also drops any pending prefix.
    always_comb begin
        scan_code_d   = scan_code_q;
        scan_valid_d  = rx_valid;
        frame_error_d = rx_bad | rx_timeout;
        break_pend_d  = break_pend_q;
        ext_pend_d    = ext_pend_q;
        if (rx_valid) begin
            scan_code_d = rx_byte;
            if (rx_byte == SC_BREAK) begin
                break_pend_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_pend_d = 1'b1;
            end else begin
                break_pend_d = 1'b0;
                ext_pend_d   = 1'b0;
            end
        end else if (rx_bad) begin
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_code_q   <= 8'h00;
            scan_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            break_pend_q  <= 1'b0;
            ext_pend_q    <= 1'b0;
        end else begin
            scan_code_q   <= scan_code_d;
            scan_valid_q  <= scan_valid_d;
            frame_error_q <= frame_error_d;
            break_pend_q  <= break_pend_d;
            ext_pend_q    <= ext_pend_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            always_ff @(posedge clk) begin
                if (reset) begin
                    key_q[gi] <= 1'b0;
                end else if (plain_byte && !ext_pend_q && (rx_byte == KEY_CODES[gi])) begin
                    key_q[gi] <= ~break_pend_q;
                end
            end
        end
    endgenerate

    assign {key_esc, key_space, key_S, key_X, key_D, key_W, key_A} = key_q;
    assign scan_code   = scan_code_q;
    assign scan_valid  = scan_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios then random scan-code traffic.
module tb_ps2_key_decoder;

    localparam int TIMEOUT = 300;
    localparam int SYNC    = 2;
    localparam int HALF    = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic       key_A, key_W, key_D, key_X, key_S, key_space, key_esc;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;

    int tests = 0;
    int failures = 0;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .key_A       (key_A),
        .key_W       (key_W),
        .key_D       (key_D),
        .key_X       (key_X),
        .key_S       (key_S),
        .key_space   (key_space),
        .key_esc     (key_esc),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    // Observation counters, written only by the monitor.
    int         cyc = 0;
    int         sv_cnt = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    int         long_cnt = 0;
    int         fe_cyc = 0;
    logic       sv_prev = 1'b0;
    logic       fe_prev = 1'b0;
    logic [6:0] keys_at_valid = '0;

    wire [6:0] dut_keys = {key_esc, key_space, key_S, key_X, key_D, key_W, key_A};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scan_valid) begin
            sv_cnt        <= sv_cnt + 1;
            keys_at_valid <= dut_keys;
        end
        if (frame_error) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (scan_valid && frame_error) both_cnt <= both_cnt + 1;
        if ((scan_valid && sv_prev) || (frame_error && fe_prev)) long_cnt <= long_cnt + 1;
        sv_prev <= scan_valid;
        fe_prev <= frame_error;
    end

    // Reference model: key levels derived from the byte stream by the decoding rules.
    logic [6:0] m_keys;
    logic [7:0] m_code;
    bit         m_brk;
    bit         m_ext;
    int         last_fall;

    function automatic int key_index(input logic [7:0] b);
        case (b)
            8'h1C:   return 0;
            8'h1D:   return 1;
            8'h23:   return 2;
            8'h22:   return 3;
            8'h1B:   return 4;
            8'h29:   return 5;
            8'h76:   return 6;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_keys = '0;
        m_code = 8'h00;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        int k;
        if (bad) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            m_code = b;
            if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else begin
                k = key_index(b);
                if (!m_ext && k >= 0) m_keys[k] = !m_brk;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = fr[i];
            tick(HALF);
            PS2_CLK   = 1'b0;
            last_fall = cyc;
            tick(HALF);
            PS2_CLK   = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Sends one full frame, updates the model and compares every observable.
    task automatic frame(input string tag, input logic [7:0] b, input bit bad);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bits(make_frame(b, bad), 11);
        tick(4);
        model_byte(b, bad);
        check({tag, ".keys"}, 32'(dut_keys), 32'(m_keys));
        check({tag, ".code"}, 32'(scan_code), 32'(m_code));
        check({tag, ".nvalid"}, 32'(sv_cnt - sv0), bad ? 32'd0 : 32'd1);
        check({tag, ".nerror"}, 32'(fe_cnt - fe0), bad ? 32'd1 : 32'd0);
        if (!bad) check({tag, ".keys_at_valid"}, 32'(keys_at_valid), 32'(m_keys));
    endtask

    initial begin
        int sv0, fe0, dt, sel;
        logic [7:0] rb;
        bit bad;

        reset    = 1'b1;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        model_reset();
        tick(5);
        check("reset.keys", 32'(dut_keys), 32'd0);
        check("reset.code", 32'(scan_code), 32'd0);
        check("reset.valid", 32'(scan_valid), 32'd0);
        check("reset.error", 32'(frame_error), 32'd0);
        reset = 1'b0;
        tick(10);

        // Make and break of A.
        frame("makeA", 8'h1C, 1'b0);
        check("makeA.key_A", 32'(key_A), 32'd1);
        frame("brkA_f0", 8'hF0, 1'b0);
        frame("brkA_1c", 8'h1C, 1'b0);
        check("brkA.key_A", 32'(key_A), 32'd0);

        // Space and Esc with a break of space only.
        sv0 = sv_cnt;
        frame("space", 8'h29, 1'b0);
        frame("esc", 8'h76, 1'b0);
        frame("brksp_f0", 8'hF0, 1'b0);
        frame("brksp_29", 8'h29, 1'b0);
        check("space.key_space", 32'(key_space), 32'd0);
        check("space.key_esc", 32'(key_esc), 32'd1);
        check("space.nvalid4", 32'(sv_cnt - sv0), 32'd4);

        // Extended prefix suppresses the key update.
        frame("ext_e0", 8'hE0, 1'b0);
        frame("ext_1c", 8'h1C, 1'b0);
        check("ext.key_A", 32'(key_A), 32'd0);
        frame("after_ext", 8'h1C, 1'b0);
        check("after_ext.key_A", 32'(key_A), 32'd1);

        // Parity error then a good frame.
        frame("bad_1d", 8'h1D, 1'b1);
        check("bad_1d.key_W", 32'(key_W), 32'd0);
        check("bad_1d.code", 32'(scan_code), 32'h1C);
        frame("good_1d", 8'h1D, 1'b0);
        check("good_1d.key_W", 32'(key_W), 32'd1);

        // Partial frame aborted by the inter-edge timeout.
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bits(make_frame(8'h23, 1'b0), 5);
        tick(TIMEOUT + 20);
        check("tmo.nerror", 32'(fe_cnt - fe0), 32'd1);
        check("tmo.nvalid", 32'(sv_cnt - sv0), 32'd0);
        dt = fe_cyc - last_fall;
        check("tmo.latency_in_range",
              32'((dt >= TIMEOUT + SYNC + 1) && (dt <= TIMEOUT + SYNC + 3)), 32'd1);
        frame("after_tmo", 8'h23, 1'b0);
        check("after_tmo.key_D", 32'(key_D), 32'd1);

        // Reset in the middle of a frame.
        frame("hold_S", 8'h1B, 1'b0);
        check("hold_S.key_S", 32'(key_S), 32'd1);
        send_bits(make_frame(8'h22, 1'b0), 6);
        reset = 1'b1;
        tick(1);
        model_reset();
        check("midrst.keys", 32'(dut_keys), 32'd0);
        check("midrst.code", 32'(scan_code), 32'd0);
        reset = 1'b0;
        tick(10);
        frame("after_rst", 8'h22, 1'b0);
        check("after_rst.key_X", 32'(key_X), 32'd1);

        // Random traffic drawn mostly from mapped codes and prefixes.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                7:       rb = 8'hF0;
                8:       rb = 8'hE0;
                9:       rb = 8'($urandom_range(0, 255));
                default: rb = KEY_TABLE(sel);
            endcase
            bad = ($urandom_range(0, 7) == 0);
            frame($sformatf("rnd%0d", n), rb, bad);
        end

        check("never_both", 32'(both_cnt), 32'd0);
        check("single_cycle_pulses", 32'(long_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    function automatic logic [7:0] KEY_TABLE(input int i);
        case (i)
            0:       return 8'h1C;
            1:       return 8'h1D;
            2:       return 8'h23;
            3:       return 8'h22;
            4:       return 8'h1B;
            5:       return 8'h29;
            default: return 8'h76;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
